// File: rtl/nibble_serial_adder.sv
// Nibble-serial sequencer driving an external combinational 4-bit ripple-carry adder.
// Optional macro NIBBLE_SUB_EN adds a sub input that turns the operation into op_a - op_b.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
`ifdef NIBBLE_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic [3:0]       rca_a,
    output logic [3:0]       rca_b,
    output logic             rca_cin,
    input  logic [3:0]       rca_sum,
    input  logic             rca_cout
);

    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nx_s;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic              carry_r;
    logic [IDXW-1:0]   idx_r;
    logic [WIDTH-1:0]  result_r;
    logic              cout_r;
    logic              busy_r;
    logic              done_r;
    logic              last_s;
    logic              accept_s;
    logic              sub_s;
    logic [3:0]        rca_a_s;
    logic [3:0]        rca_b_s;
    logic              rca_cin_s;

`ifdef NIBBLE_SUB_EN
    assign sub_s = sub;
`else
    assign sub_s = 1'b0;
`endif

    assign last_s   = (idx_r == IDXW'(NIB - 1));
    assign accept_s = start && ((state_r == IDLE) || (state_r == DONE));

    // Next-state decode; a start in DONE re-enters RUN with no idle gap
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_nx_s = RUN;
                else       state_nx_s = IDLE;
            end
            RUN: begin
                if (last_s) state_nx_s = DONE;
                else        state_nx_s = RUN;
            end
            DONE: begin
                if (start) state_nx_s = RUN;
                else       state_nx_s = IDLE;
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // RCA operand drive: selected nibble while running, zeros otherwise
    always_comb begin
        rca_a_s   = 4'd0;
        rca_b_s   = 4'd0;
        rca_cin_s = 1'b0;
        if (state_r == RUN) begin
            rca_a_s   = 4'(a_r >> {idx_r, 2'b00});
            rca_b_s   = 4'(b_r >> {idx_r, 2'b00});
            rca_cin_s = carry_r;
        end else begin
            rca_a_s   = 4'd0;
            rca_b_s   = 4'd0;
            rca_cin_s = 1'b0;
        end
    end

    // State, operand latch and per-nibble accumulation
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= IDLE;
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            carry_r  <= 1'b0;
            idx_r    <= {IDXW{1'b0}};
            result_r <= {WIDTH{1'b0}};
            cout_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s == RUN);
            done_r  <= (state_nx_s == DONE);
            if (accept_s) begin
                // Subtraction is A + ~B + 1, so the inverted operand and forced carry are latched here
                a_r     <= op_a;
                b_r     <= sub_s ? ~op_b : op_b;
                carry_r <= sub_s ? 1'b1 : cin;
                idx_r   <= {IDXW{1'b0}};
            end else if (state_r == RUN) begin
                result_r[{idx_r, 2'b00} +: 4] <= rca_sum;
                carry_r                       <= rca_cout;
                idx_r                         <= idx_r + IDXW'(1);
                if (last_s) cout_r <= rca_cout;
                else        cout_r <= cout_r;
            end else begin
                carry_r <= carry_r;
            end
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign result  = result_r;
    assign cout    = cout_r;
    assign rca_a   = rca_a_s;
    assign rca_b   = rca_b_s;
    assign rca_cin = rca_cin_s;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder; models the external RCA and checks against plain arithmetic.
module tb_nibble_serial_adder;

    localparam int W = 16;
    localparam int NIB = W / 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  op_a = '0;
    logic [W-1:0]  op_b = '0;
    logic          cin = 1'b0;
`ifdef NIBBLE_SUB_EN
    logic          sub_sel = 1'b0;
`endif
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          cout;
    logic [3:0]    rca_a;
    logic [3:0]    rca_b;
    logic          rca_cin;
    logic [3:0]    rca_sum;
    logic          rca_cout;

    int n_pass = 0;
    int n_total = 0;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .op_a(op_a), .op_b(op_b), .cin(cin),
`ifdef NIBBLE_SUB_EN
        .sub(sub_sel),
`endif
        .busy(busy), .done(done), .result(result), .cout(cout),
        .rca_a(rca_a), .rca_b(rca_b), .rca_cin(rca_cin),
        .rca_sum(rca_sum), .rca_cout(rca_cout)
    );

    always #5 clk = ~clk;

    // External 4-bit adder
    always_comb {rca_cout, rca_sum} = 5'(rca_a) + 5'(rca_b) + 5'(rca_cin);

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        op_a = a; op_b = b; cin = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          output int nbusy, output bit got);
        launch(a, b, c);
        nbusy = 0; got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (done) begin got = 1'b1; break; end
            if (busy) nbusy++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        n_total++; if ({busy, done, cout} !== 3'b000) $display("FAIL reset_flags got %b want 000", {busy, done, cout}); else n_pass++;
        n_total++; if (result !== 16'h0000) $display("FAIL reset_result got %h want 0000", result); else n_pass++;
        reset_n = 1'b1;
        @(negedge clk);
        n_total++; if ({rca_a, rca_b, rca_cin} !== 9'd0) $display("FAIL idle_rca got %h want 0", {rca_a, rca_b, rca_cin}); else n_pass++;
    endtask

    task automatic test_basic_add;
        int nb; bit got;
        run_op(16'h1234, 16'h4321, 1'b0, nb, got);
        n_total++; if (!got) $display("FAIL basic_timeout got %0d want 1", got); else n_pass++;
        n_total++; if (nb !== 4) $display("FAIL basic_busy_cycles got %0d want %0d", nb, 4); else n_pass++;
        n_total++; if (result !== 16'h5555 || cout !== 1'b0) $display("FAIL basic_sum got %b_%h want 0_5555", cout, result); else n_pass++;
        @(negedge clk);
        n_total++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL basic_done_pulse got %b%b want 00", done, busy); else n_pass++;
        n_total++; if (result !== 16'h5555) $display("FAIL basic_hold got %h want 5555", result); else n_pass++;
    endtask

    task automatic test_carry_chain;
        logic [W-1:0] av [2] = '{16'hFFFF, 16'h0000};
        logic [W-1:0] bv [2] = '{16'h0001, 16'h0000};
        logic         cv [2] = '{1'b0, 1'b1};
        for (int t = 0; t < 2; t++) begin
            int nb; bit got;
            logic [3:0] seen, want;
            logic [W:0] exp;
            for (int k = 0; k < NIB; k++) begin
                int unsigned m;
                m = (32'd1 << (4 * k)) - 32'd1;
                want[k] = 1'(((int'(av[t]) & m) + (int'(bv[t]) & m) + int'(cv[t])) >> (4 * k));
            end
            exp = {1'b0, av[t]} + {1'b0, bv[t]} + 17'(cv[t]);
            launch(av[t], bv[t], cv[t]);
            nb = 0; got = 1'b0; seen = 4'd0;
            for (int k = 0; k < 20; k++) begin
                if (done) begin got = 1'b1; break; end
                if (busy && nb < NIB) seen[nb] = rca_cin;
                if (busy) nb++;
                @(negedge clk);
            end
            n_total++; if (!got || nb !== NIB) $display("FAIL chain_timing got %0d/%0d want 1/%0d", got, nb, NIB); else n_pass++;
            n_total++; if (seen !== want) $display("FAIL chain_cin_seq got %b want %b", seen, want); else n_pass++;
            n_total++; if ({cout, result} !== exp) $display("FAIL chain_sum got %h want %h", {cout, result}, exp); else n_pass++;
        end
    endtask

    task automatic test_back_to_back;
        int nb; bit got;
        launch(16'h2222, 16'h3333, 1'b1);
        start = 1'b1; op_a = 16'h1111; op_b = 16'h1111; cin = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (done) begin got = 1'b1; break; end
            @(negedge clk);
        end
        n_total++; if (!got) $display("FAIL hold_timeout got %0d want 1", got); else n_pass++;
        n_total++; if (result !== 16'h5556 || cout !== 1'b0) $display("FAIL hold_ignored got %b_%h want 0_5556", cout, result); else n_pass++;
        launch(16'h00F0, 16'h0F0F, 1'b0);
        n_total++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL b2b_no_gap got %b%b want 10", busy, done); else n_pass++;
        nb = 1; got = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            if (done) begin got = 1'b1; break; end
            if (busy) nb++;
            @(negedge clk);
        end
        n_total++; if (!got || nb !== 4) $display("FAIL b2b_timing got %0d/%0d want 1/4", got, nb); else n_pass++;
        n_total++; if (result !== 16'h0FFF || cout !== 1'b0) $display("FAIL b2b_sum got %b_%h want 0_0fff", cout, result); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run;
        int nb; bit got;
        launch(16'hFFFF, 16'h0001, 1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        n_total++; if ({busy, done, cout} !== 3'b000 || result !== 16'h0000)
            $display("FAIL midrun_reset got %b_%h want 000_0000", {busy, done, cout}, result); else n_pass++;
        n_total++; if ({rca_a, rca_b, rca_cin} !== 9'd0) $display("FAIL midrun_rca got %h want 0", {rca_a, rca_b, rca_cin}); else n_pass++;
        reset_n = 1'b1;
        @(negedge clk);
        run_op(16'h1234, 16'h0001, 1'b0, nb, got);
        n_total++; if (!got || nb !== 4 || result !== 16'h1235 || cout !== 1'b0)
            $display("FAIL post_reset_op got %0d/%0d/%h want 1/4/1235", got, nb, result); else n_pass++;
    endtask

    task automatic test_random;
        for (int i = 0; i < 128; i++) begin
            int nb; bit got;
            logic [W-1:0] a, b; logic c; logic [W:0] exp;
            a = W'($urandom); b = W'($urandom); c = 1'($urandom);
            exp = 17'(int'(a) + int'(b) + int'(c));
            run_op(a, b, c, nb, got);
            n_total++; if (!got || nb !== NIB || {cout, result} !== exp)
                $display("FAIL rand_%0d got %0d/%0d/%h want 1/%0d/%h", i, got, nb, {cout, result}, NIB, exp); else n_pass++;
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
    endtask

`ifdef NIBBLE_SUB_EN
    task automatic test_sub;
        logic [W-1:0] av [3] = '{16'h0005, 16'h0010, 16'hBEEF};
        logic [W-1:0] bv [3] = '{16'h0007, 16'h0001, 16'h1234};
        sub_sel = 1'b1;
        for (int t = 0; t < 3; t++) begin
            int nb; bit got; logic [W-1:0] er; logic ec;
            er = W'(int'(av[t]) - int'(bv[t]));
            ec = (av[t] >= bv[t]);
            run_op(av[t], bv[t], 1'b0, nb, got);
            n_total++; if (!got || result !== er || cout !== ec)
                $display("FAIL sub_%0d got %b_%h want %b_%h", t, cout, result, ec, er); else n_pass++;
        end
        sub_sel = 1'b0;
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset;
        test_basic_add;
        test_carry_chain;
        test_back_to_back;
        test_reset_mid_run;
        test_random;
`ifdef NIBBLE_SUB_EN
        test_sub;
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
